// File: rtl/tlb_cp0_ctrl_if.sv
// Pipeline-side port bundle of the TLB/CP0 controller: TLB op handshake plus
// the mtc0/mfc0 register access path.
interface tlb_cp0_ctrl_if;
    // Handshake: an op transfers on a cycle where op_valid && op_ready; the
    // requester holds op_code stable while op_valid is high. Nothing is queued:
    // op_valid is ignored while op_ready is low. op_done pulses once per
    // accepted op, in the cycle the op takes effect.
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic        op_done;
    logic        mtc0_we;
    logic [2:0]  cp0_sel;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;

    modport master (
        output op_valid, op_code, mtc0_we, cp0_sel, mtc0_wdata,
        input  op_ready, op_done, mfc0_rdata
    );

    modport slave (
        input  op_valid, op_code, mtc0_we, cp0_sel, mtc0_wdata,
        output op_ready, op_done, mfc0_rdata
    );
endinterface

// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB register file (Index/EntryHi/EntryLo0/EntryLo1/Random) and the
// single-cycle TLBP/TLBR/TLBWI/TLBWR sequencer that drives the TLB ports.
module tlb_cp0_ctrl #(
    parameter int  TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic           clk,
    input  logic           reset,
    tlb_cp0_ctrl_if.slave  cpu,
    output logic [7:0]     entryhi_asid,
    output logic [18:0]    s_vpn2,
    output logic           s_odd_page,
    output logic [7:0]     s_asid,
    input  logic           s_found,
    input  logic [IW-1:0]  s_index,
    output logic [IW-1:0]  r_index,
    input  logic [18:0]    r_vpn2,
    input  logic [7:0]     r_asid,
    input  logic           r_g,
    input  logic [19:0]    r_pfn0,
    input  logic [2:0]     r_c0,
    input  logic           r_d0,
    input  logic           r_v0,
    input  logic [19:0]    r_pfn1,
    input  logic [2:0]     r_c1,
    input  logic           r_d1,
    input  logic           r_v1,
    output logic           we,
    output logic [IW-1:0]  w_index,
    output logic [18:0]    w_vpn2,
    output logic [7:0]     w_asid,
    output logic           w_g,
    output logic [19:0]    w_pfn0,
    output logic [2:0]     w_c0,
    output logic           w_d0,
    output logic           w_v0,
    output logic [19:0]    w_pfn1,
    output logic [2:0]     w_c1,
    output logic           w_d1,
    output logic           w_v1,
    output logic [1:0]     dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_READ, S_WRITE} state_t;

    state_t        state_q, state_d;
    logic          p_q, p_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [18:0]   vpn2_q, vpn2_d;
    logic [7:0]    asid_q, asid_d;
    logic [25:0]   lo0_q, lo0_d;   // {PFN, C, D, V, G}
    logic [25:0]   lo1_q, lo1_d;
    logic [IW-1:0] rand_q, rand_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p_q      <= 1'b0;
            idx_q    <= '0;
            vpn2_q   <= '0;
            asid_q   <= '0;
            lo0_q    <= '0;
            lo1_q    <= '0;
            rand_q   <= IW'(TLBNUM - 1);
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            vpn2_q   <= vpn2_d;
            asid_q   <= asid_d;
            lo0_q    <= lo0_d;
            lo1_q    <= lo1_d;
            rand_q   <= rand_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        idx_d    = idx_q;
        vpn2_d   = vpn2_q;
        asid_d   = asid_q;
        lo0_d    = lo0_q;
        lo1_d    = lo1_q;
        wr_idx_d = wr_idx_q;
        rand_d   = (rand_q == '0) ? IW'(TLBNUM - 1) : rand_q - IW'(1);
        case (state_q)
            S_IDLE: begin
                if (cpu.mtc0_we) begin
                    case (cpu.cp0_sel)
                        3'd0: begin
                            p_d   = cpu.mtc0_wdata[31];
                            idx_d = cpu.mtc0_wdata[IW-1:0];
                        end
                        3'd1: lo0_d = cpu.mtc0_wdata[25:0];
                        3'd2: lo1_d = cpu.mtc0_wdata[25:0];
                        3'd3: begin
                            vpn2_d = cpu.mtc0_wdata[31:13];
                            asid_d = cpu.mtc0_wdata[7:0];
                        end
                        default: ;
                    endcase
                end
                if (cpu.op_valid) begin
                    case (cpu.op_code)
                        2'b00:   state_d = S_PROBE;
                        2'b01:   state_d = S_READ;
                        default: state_d = S_WRITE;
                    endcase
                    // Write target is frozen at acceptance; idx_d already holds a same-cycle mtc0 to Index.
                    wr_idx_d = cpu.op_code[0] ? rand_q : idx_d;
                end
            end
            S_PROBE: begin
                p_d     = ~s_found;
                idx_d   = s_found ? s_index : '0;
                state_d = S_IDLE;
            end
            S_READ: begin
                vpn2_d  = r_vpn2;
                asid_d  = r_asid;
                lo0_d   = {r_pfn0, r_c0, r_d0, r_v0, r_g};
                lo1_d   = {r_pfn1, r_c1, r_d1, r_v1, r_g};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu.mfc0_rdata = '0;
        case (cpu.cp0_sel)
            3'd0:    cpu.mfc0_rdata = {p_q, {(31-IW){1'b0}}, idx_q};
            3'd1:    cpu.mfc0_rdata = {6'b0, lo0_q};
            3'd2:    cpu.mfc0_rdata = {6'b0, lo1_q};
            3'd3:    cpu.mfc0_rdata = {vpn2_q, 5'b0, asid_q};
            3'd4:    cpu.mfc0_rdata = {{(32-IW){1'b0}}, rand_q};
            default: cpu.mfc0_rdata = '0;
        endcase
    end

    // Reset gates the status outputs so an op caught by reset never completes.
    assign cpu.op_ready = (state_q == S_IDLE) || reset;
    assign cpu.op_done  = (state_q != S_IDLE) && !reset;
    assign we           = (state_q == S_WRITE) && !reset;

    assign entryhi_asid = asid_q;
    assign s_vpn2       = vpn2_q;
    assign s_asid       = asid_q;
    assign s_odd_page   = 1'b0;
    assign r_index      = idx_q;

    assign w_index = wr_idx_q;
    assign w_vpn2  = vpn2_q;
    assign w_asid  = asid_q;
    assign w_g     = lo0_q[0] & lo1_q[0];
    assign w_pfn0  = lo0_q[25:6];
    assign w_c0    = lo0_q[5:3];
    assign w_d0    = lo0_q[2];
    assign w_v0    = lo0_q[1];
    assign w_pfn1  = lo1_q[25:6];
    assign w_c1    = lo1_q[5:3];
    assign w_d1    = lo1_q[2];
    assign w_v1    = lo1_q[1];
    assign dbg_state = state_q;
endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Bench for tlb_cp0_ctrl: directed scenarios followed by randomized traffic,
// all checked against a word-level register model with an expected-write queue.
module tb_tlb_cp0_ctrl;
    localparam int TLBNUM = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tlb_cp0_ctrl_if bus();

    logic [7:0]  entryhi_asid;
    logic [18:0] s_vpn2;
    logic        s_odd_page;
    logic [7:0]  s_asid;
    logic        s_found;
    logic [3:0]  s_index;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;
    logic        we;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        w_d0, w_v0, w_d1, w_v1;
    logic [1:0]  dbg_state;

    tlb_cp0_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset), .cpu(bus),
        .entryhi_asid(entryhi_asid), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .r_index(r_index),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Architectural model: registers as 32-bit words, Random as an integer.
    logic [31:0] m_idx, m_hi, m_lo0, m_lo1;
    int          m_rand = TLBNUM - 1;
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    logic [1:0]  m_op = 2'b00;
    logic [3:0]  exp_q[$];

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] sel);
        case (sel)
            3'd0:    return m_idx;
            3'd1:    return m_lo0;
            3'd2:    return m_lo1;
            3'd3:    return m_hi;
            3'd4:    return 32'(m_rand);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs();
        bit exp_we;
        exp_we = !reset && m_busy && m_op[1];
        chk(32'(bus.op_ready), 32'(reset || !m_busy), "op_ready");
        chk(32'(bus.op_done), 32'(!reset && m_busy), "op_done");
        chk(32'(we), 32'(exp_we), "we");
        if (m_valid) begin
            chk(bus.mfc0_rdata, exp_rd(bus.cp0_sel), "mfc0_rdata");
            chk(32'(s_vpn2), 32'(m_hi[31:13]), "s_vpn2");
            chk(32'(s_asid), 32'(m_hi[7:0]), "s_asid");
            chk(32'(entryhi_asid), 32'(m_hi[7:0]), "entryhi_asid");
            chk(32'(r_index), 32'(m_idx[3:0]), "r_index");
            chk(32'(s_odd_page), 32'h0, "s_odd_page");
        end
        if (exp_we) begin
            chk(32'(w_index), 32'(exp_q.pop_front()), "w_index");
            chk(32'(w_vpn2), 32'(m_hi[31:13]), "w_vpn2");
            chk(32'(w_asid), 32'(m_hi[7:0]), "w_asid");
            chk(32'(w_g), 32'(m_lo0[0] & m_lo1[0]), "w_g");
            chk(32'(w_pfn0), 32'(m_lo0[25:6]), "w_pfn0");
            chk(32'({w_c0, w_d0, w_v0}), 32'(m_lo0[5:1]), "w_cdv0");
            chk(32'(w_pfn1), 32'(m_lo1[25:6]), "w_pfn1");
            chk(32'({w_c1, w_d1, w_v1}), 32'(m_lo1[5:1]), "w_cdv1");
        end
    endtask

    task automatic model_edge();
        int next_rand;
        if (reset) begin
            m_idx = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0;
            m_rand = TLBNUM - 1; m_busy = 1'b0; m_valid = 1'b1;
            exp_q.delete();
        end else begin
            next_rand = (m_rand + TLBNUM - 1) % TLBNUM;
            if (m_busy) begin
                case (m_op)
                    2'd0: m_idx = s_found ? 32'(s_index) : 32'h8000_0000;
                    2'd1: begin
                        m_hi  = (32'(r_vpn2) << 13) | 32'(r_asid);
                        m_lo0 = (32'(r_pfn0) << 6) | (32'(r_c0) << 3) | (32'(r_d0) << 2) | (32'(r_v0) << 1) | 32'(r_g);
                        m_lo1 = (32'(r_pfn1) << 6) | (32'(r_c1) << 3) | (32'(r_d1) << 2) | (32'(r_v1) << 1) | 32'(r_g);
                    end
                    default: ;
                endcase
                m_busy = 1'b0;
            end else begin
                if (bus.mtc0_we) begin
                    case (bus.cp0_sel)
                        3'd0: m_idx = bus.mtc0_wdata & 32'h8000_000F;
                        3'd1: m_lo0 = bus.mtc0_wdata & 32'h03FF_FFFF;
                        3'd2: m_lo1 = bus.mtc0_wdata & 32'h03FF_FFFF;
                        3'd3: m_hi  = bus.mtc0_wdata & 32'hFFFF_E0FF;
                        default: ;
                    endcase
                end
                if (bus.op_valid) begin
                    m_busy = 1'b1;
                    m_op = bus.op_code;
                    if (bus.op_code == 2'd3) exp_q.push_back(4'(m_rand));
                    else if (bus.op_code == 2'd2) exp_q.push_back(m_idx[3:0]);
                end
            end
            m_rand = next_rand;
        end
    endtask

    // Inputs are driven at the falling edge; checks settle 1ns later.
    task automatic run_cycle();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.mtc0_we = 1'b0;
        bus.cp0_sel = 3'd0; bus.mtc0_wdata = 32'h0;
        s_found = 1'b0; s_index = 4'h0;
        r_vpn2 = '0; r_asid = '0; r_g = 1'b0;
        r_pfn0 = '0; r_c0 = '0; r_d0 = 1'b0; r_v0 = 1'b0;
        r_pfn1 = '0; r_c1 = '0; r_d1 = 1'b0; r_v1 = 1'b0;
    endtask

    task automatic mtc0(input logic [2:0] sel, input logic [31:0] data);
        bus.mtc0_we = 1'b1; bus.cp0_sel = sel; bus.mtc0_wdata = data; bus.op_valid = 1'b0;
        run_cycle();
        bus.mtc0_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] code);
        bus.op_valid = 1'b1; bus.op_code = code; bus.mtc0_we = 1'b0;
        run_cycle();
        bus.op_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        bus.mtc0_we = 1'b0; bus.op_valid = 1'b0; bus.cp0_sel = sel;
        #1;
        chk(bus.mfc0_rdata, exp, tag);
        run_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        run_cycle();
        run_cycle();
        reset = 1'b0;

        // Cycle 0..4 after reset: reset values; TLBWR at cycle 5 targets 15-5.
        read_reg(3'd4, 32'd15, "rand_c0");
        read_reg(3'd0, 32'h0, "idx_rst");
        read_reg(3'd3, 32'h0, "hi_rst");
        read_reg(3'd1, 32'h0, "lo0_rst");
        read_reg(3'd2, 32'h0, "lo1_rst");
        issue(2'd3);
        #1;
        chk(32'(we), 32'h1, "tlbwr_we");
        chk(32'(w_index), 32'd10, "tlbwr_index");
        run_cycle();
        for (int k = 7; k <= 17; k++) read_reg(3'd4, 32'((47 - k) % 16), "rand_wrap");

        // Probe hit and miss.
        mtc0(3'd3, 32'h0000_2005);
        s_found = 1'b1; s_index = 4'd7;
        issue(2'd0);
        #1;
        chk(32'(bus.op_done), 32'h1, "tlbp_done");
        chk(32'(s_vpn2), 32'h1, "tlbp_s_vpn2");
        chk(32'(s_asid), 32'h5, "tlbp_s_asid");
        run_cycle();
        s_found = 1'b0;
        read_reg(3'd0, 32'h0000_0007, "tlbp_hit_idx");
        issue(2'd0);
        run_cycle();
        read_reg(3'd0, 32'h8000_0000, "tlbp_miss_idx");

        // TLBWI then TLBR read-back.
        mtc0(3'd0, 32'd3);
        mtc0(3'd3, 32'hABCD_E0FF);
        mtc0(3'd1, 32'h0000_0047);
        mtc0(3'd2, 32'h0000_0086);
        issue(2'd2);
        #1;
        chk(32'(we), 32'h1, "tlbwi_we");
        chk(32'(w_index), 32'd3, "tlbwi_index");
        chk(32'(w_vpn2), 32'h55E6F, "tlbwi_vpn2");
        chk(32'(w_asid), 32'hFF, "tlbwi_asid");
        chk(32'(w_g), 32'h0, "tlbwi_g");
        run_cycle();
        #1;
        chk(32'(we), 32'h0, "tlbwi_we_once");
        run_cycle();
        mtc0(3'd3, 32'h0);
        r_vpn2 = 19'h55E6F; r_asid = 8'hFF; r_g = 1'b0;
        r_pfn0 = 20'd1; r_c0 = 3'd0; r_d0 = 1'b1; r_v0 = 1'b1;
        r_pfn1 = 20'd2; r_c1 = 3'd0; r_d1 = 1'b1; r_v1 = 1'b1;
        issue(2'd1);
        run_cycle();
        idle_inputs();
        read_reg(3'd3, 32'hABCD_E0FF, "tlbr_hi");
        read_reg(3'd1, 32'h0000_0046, "tlbr_lo0");
        read_reg(3'd2, 32'h0000_0086, "tlbr_lo1");

        // Back-to-back TLBPs with mtc0 in the accept and busy cycles.
        s_found = 1'b1; s_index = 4'h9;
        bus.op_code = 2'd0; bus.cp0_sel = 3'd3;
        for (int i = 0; i < 6; i++) begin
            bus.op_valid = 1'b1;
            bus.mtc0_we = (i < 2);
            bus.mtc0_wdata = (i == 0) ? 32'h0000_4003 : 32'h1111_2222;
            #1;
            chk(32'(bus.op_done), 32'(i % 2), "b2b_done");
            if (i == 1) chk(32'(s_vpn2), 32'h2, "mtc0_same_cycle");
            if (i == 2) chk(bus.mfc0_rdata, 32'h0000_4003, "mtc0_busy_dropped");
            run_cycle();
        end
        idle_inputs();

        // Reset during WRITE aborts the op.
        mtc0(3'd0, 32'd5);
        issue(2'd2);
        reset = 1'b1;
        #1;
        chk(32'(we), 32'h0, "rst_write_we");
        chk(32'(bus.op_done), 32'h0, "rst_write_done");
        run_cycle();
        reset = 1'b0;
        read_reg(3'd4, 32'd15, "rst_write_rand");
        read_reg(3'd0, 32'h0, "rst_write_idx");
        read_reg(3'd3, 32'h0, "rst_write_hi");
        read_reg(3'd1, 32'h0, "rst_write_lo0");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op_code = 2'($urandom_range(0, 3));
            bus.mtc0_we = 1'($urandom_range(0, 1));
            bus.cp0_sel = 3'($urandom_range(0, 7));
            bus.mtc0_wdata = $urandom;
            s_found = 1'($urandom_range(0, 1));
            s_index = 4'($urandom_range(0, 15));
            r_vpn2 = 19'($urandom); r_asid = 8'($urandom); r_g = 1'($urandom);
            r_pfn0 = 20'($urandom); r_c0 = 3'($urandom); r_d0 = 1'($urandom); r_v0 = 1'($urandom);
            r_pfn1 = 20'($urandom); r_c1 = 3'($urandom); r_d1 = 1'($urandom); r_v1 = 1'($urandom);
            run_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        run_cycle();
        run_cycle();
        chk(32'(exp_q.size()), 32'h0, "write_queue_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
